// File: rtl/loader_defs.sv
// loader_defs: FSM encodings and frame-field constants shared by the
// UART instruction-memory loader and its byte receiver.
package loader_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Data bytes of a word arrive little-endian; byte 3 completes it.
  localparam logic [1:0] LAST_BYTE = 2'd3;
  localparam int         LEN_W     = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 2-flop rx synchronizer.
// Ports: clk, rst (async high), rx in; data[7:0], valid, frame_err out.
module uart_rx_byte
  import loader_defs::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_q;
  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (st)
        RX_IDLE: begin
          if (rx_q && !rx_s2) begin
            st  <= RX_START;
            cnt <= HALF;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (rx_s2) begin
            // Line went back high: glitch, not a start bit.
            st <= RX_IDLE;
          end else begin
            st      <= RX_DATA;
            cnt     <= FULL;
            bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            shreg   <= {rx_s2, shreg[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            st <= RX_IDLE;
            if (rx_s2) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: loads N words over UART into instruction memory.
// Ports: clk, rst, rx, start in; imem_we/addr/wdata, cpu_hold, busy,
// done, err out. Define LOADER_CHECKSUM_EN for the XOR trailer byte.
module uart_imem_loader
  import loader_defs::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WONE = (ADDR_WIDTH + 1)'(1);

  logic [2:0]          state;
  logic [LEN_W-1:0]    len;
  logic [ADDR_WIDTH:0] wcnt;
  logic [1:0]          bsel;
  logic [31:0]         word;
  logic                we_q;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ferr;
  logic [LEN_W-1:0]    n_rx;
  logic                len_big;
  logic                last_word;
  logic                active;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  localparam logic [2:0] ST_FINAL = ST_CHK;
`else
  localparam logic [2:0] ST_FINAL = ST_DONE;
`endif

  uart_rx_byte #(
    .DIV(DIV)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  assign n_rx      = {rx_data, len[7:0]};
  assign len_big   = 32'(n_rx) > MAX_WORDS;
  assign last_word = (32'(wcnt) + 32'd1) == 32'(len);
  assign active    = state inside {ST_LEN_LO, ST_LEN_HI,
                                   ST_DATA, ST_CHK};

  assign imem_we    = we_q;
  assign imem_addr  = wcnt[ADDR_WIDTH-1:0];
  assign imem_wdata = word;
  assign busy       = active;
  assign cpu_hold   = active | (state == ST_ERR);
  assign done       = state == ST_DONE;
  assign err        = state == ST_ERR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      len   <= '0;
      wcnt  <= '0;
      bsel  <= '0;
      word  <= '0;
      we_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      // Write cycle: advance the address after the strobe.
      if (we_q) begin
        wcnt <= wcnt + WONE;
        if (last_word) state <= ST_FINAL;
      end
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state <= ST_LEN_LO;
            len   <= '0;
            wcnt  <= '0;
            bsel  <= '0;
            word  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        default: begin
          if (rx_ferr) begin
            state <= ST_ERR;
          end else if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
            if (state != ST_CHK) csum <= csum ^ rx_data;
`endif
            case (state)
              ST_LEN_LO: begin
                len[7:0] <= rx_data;
                state    <= ST_LEN_HI;
              end
              ST_LEN_HI: begin
                len <= n_rx;
                if (len_big) state <= ST_ERR;
                else if (n_rx == '0) state <= ST_FINAL;
                else state <= ST_DATA;
              end
              ST_DATA: begin
                word[{bsel, 3'b000} +: 8] <= rx_data;
                bsel <= bsel + 2'd1;
                if (bsel == LAST_BYTE) we_q <= 1'b1;
              end
`ifdef LOADER_CHECKSUM_EN
              ST_CHK: begin
                if (rx_data == csum) state <= ST_DONE;
                else state <= ST_ERR;
              end
`endif
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: randomized frames against a queue-based model
// of expected instruction-memory writes and final loader status.
module tb_uart_imem_loader;

  localparam int AW = 14;
  localparam int BT = 10;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         expq[$];
  int          checks   = 0;
  int          failures = 0;
  int          nwrites  = 0;
  logic [31:0] last_wdata = '0;

  always #5 clk = ~clk;

  uart_imem_loader #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .start     (start),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    chk("hold_rule", 32'(cpu_hold), 32'(busy | err));
    if (imem_we === 1'b1) begin
      nwrites++;
      last_wdata = imem_wdata;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we addr=%h data=%h required=none",
                 imem_addr, imem_wdata);
      end else begin
        e = expq.pop_front();
        chk("we_addr", 32'(imem_addr), 32'(e.a));
        chk("we_data", imem_wdata, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BT) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(1, 6)) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy === 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (busy === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s busy=1 required=0", tag);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_hold"}, 32'(cpu_hold), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // Build the byte stream, predict writes and final status, send it.
  task automatic run_frame(input int n, input logic [31:0] w[$],
                           input int bad_idx, input int start_at,
                           input bit bad_chk, input string tag);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [7:0] b;
    bit         exp_err;
    bit         big;
    big     = n > (1 << AW);
    exp_err = big || bad_idx >= 0 || (bad_chk && CK_EN);
    b = n[7:0];
    bytes.push_back(b);
    b = n[15:8];
    bytes.push_back(b);
    if (!big) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) begin
          b = w[i][8*k +: 8];
          bytes.push_back(b);
        end
      if (CK_EN) begin
        x = '0;
        foreach (bytes[i]) x ^= bytes[i];
        bytes.push_back(bad_chk ? (x ^ 8'h07) : x);
      end
      for (int i = 0; i < n; i++)
        if (bad_idx < 0 || (2 + 4*i + 3) < bad_idx)
          expq.push_back('{a: AW'(i), d: w[i]});
    end
    do_start();
    foreach (bytes[i]) begin
      if (i == start_at) do_start();
      if (bad_idx < 0 || i <= bad_idx)
        chk({"busy_", tag}, 32'(busy), 1);
      send_byte(bytes[i], i != bad_idx);
    end
    wait_idle(tag);
    chk({"done_", tag}, 32'(done), 32'(!exp_err));
    chk({"err_", tag}, 32'(err), 32'(exp_err));
    chk({"hold_", tag}, 32'(cpu_hold), 32'(exp_err));
    chk({"pending_", tag}, expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    logic [31:0] wq[$];
    int n0;
    int nr;
    rst   = 1'b1;
    rx    = 1'b1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    wq.delete();
    wq.push_back(32'h00A00513);
    n0 = nwrites;
    run_frame(1, wq, -1, -1, 1'b0, "single");
    chk("single_wdata", last_wdata, 32'h00A00513);
    chk("single_count", nwrites - n0, 1);

    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    n0 = nwrites;
    run_frame(3, wq, -1, 7, 1'b0, "three");
    chk("three_count", nwrites - n0, 3);

    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back($urandom);
    n0 = nwrites;
    run_frame(2, wq, 4, -1, 1'b0, "ferr");
    chk("ferr_count", nwrites - n0, 0);

    wq.delete();
    wq.push_back(32'h00A00513);
    run_frame(1, wq, -1, -1, 1'b0, "restart");

    wq.delete();
    n0 = nwrites;
    run_frame(32'h8000, wq, -1, -1, 1'b0, "big8000");
    run_frame(16385, wq, -1, -1, 1'b0, "big4001");
    run_frame(0, wq, -1, -1, 1'b0, "zero");
    chk("len_edge_count", nwrites - n0, 0);

    wq.delete();
    wq.push_back(32'hDEADBEEF);
    run_frame(1, wq, -1, -1, 1'b0, "ck_good");
    n0 = nwrites;
    run_frame(1, wq, -1, -1, 1'b1, "ck_bad");
    chk("ck_bad_count", nwrites - n0, 1);
    chk("ck_bad_word", last_wdata, 32'hDEADBEEF);

    n0 = nwrites;
    do_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    do_start();
    chk("ignored_start_busy", 32'(busy), 1);
    fork
      send_byte(8'h33, 1'b1);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("in_rst");
      end
    join
    rst = 1'b0;
    rx  = 1'b1;
    repeat (30) @(negedge clk);
    chk_zero("post_rst");
    chk("rst_count", nwrites - n0, 0);

    for (int f = 0; f < 5; f++) begin
      nr = $urandom_range(1, 4);
      wq.delete();
      for (int i = 0; i < nr; i++) wq.push_back($urandom);
      run_frame(nr, wq, -1, -1, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
